uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default oversampling ratio,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line. It resets to 1,
// which is the idle line level, so a reset never looks like a start edge.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw line through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 frame recovery with mid-bit sampling,
// glitch rejection on the start bit, stop-bit framing check and a
// single-byte output buffer with sticky overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  uart_state_t   state, state_next;
  logic [TW-1:0] tick_cnt, tick_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          rx_s;
  logic          rx_prev;
  logic          load_byte;
  logic          stop_bad;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Register FSM state, counters, shift register and the previous line sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_prev   <= 1'b1;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      if (rx_en) begin
        rx_prev <= rx_s;
      end
    end
  end

  // Next-state and datapath decisions, evaluated only on oversample ticks
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    load_byte  = 1'b0;
    stop_bad   = 1'b0;
    if (rx_en) begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            shift_next[bit_idx] = rx_s;
            tick_next           = '0;
            if (bit_idx == 3'd7) begin
              state_next = STOP;
              bit_next   = '0;
            end else begin
              bit_next = bit_idx + 3'd1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            tick_next  = '0;
            state_next = IDLE;
            if (rx_s) begin
              load_byte = 1'b1;
            end else begin
              stop_bad = 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          tick_next  = '0;
        end
      endcase
    end
  end

  // Output buffer: byte load, consumer handshake, framing pulse, sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (load_byte) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
        if (data_valid && !rd) begin
          overrun <= 1'b1;
        end
      end else if (rd && data_valid) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
